// File: rtl/pu_riscv_mul_pipe.sv
// pu_riscv_mul_pipe: pipelined RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU/MULW) with tag, stall and flush
module pu_riscv_mul_pipe #(
  parameter int XLEN    = 64,
  parameter int LATENCY = 3,
  parameter int TAGW    = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_opa,
  input  logic [XLEN-1:0] in_opb,
  input  logic [TAGW-1:0] in_tag,
  input  logic            xlen32,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_r,
  output logic [TAGW-1:0] out_tag,
  output logic            out_illegal,
  output logic            busy
);
  // p carries {|a|, |b|} until the multiply boundary, the full product afterwards
  localparam int MUL_AT = (LATENCY == 1) ? 1 : 2;
  typedef struct packed {
    logic            vld;
    logic            ill;
    logic            neg;
    logic [1:0]      sel;
    logic [TAGW-1:0] tag;
    logic [2*XLEN-1:0] p;
  } stg_t;
  function automatic stg_t mul_at(stg_t s, int k);
    stg_t m = s;
    if (k == MUL_AT) m.p = (2*XLEN)'(s.p[2*XLEN-1:XLEN]) * (2*XLEN)'(s.p[XLEN-1:0]);
    return m;
  endfunction
  logic              adv, mid_busy, na, nb;
  logic [XLEN-1:0]   ra, rb, ma, mb, res;
  logic [2*XLEN-1:0] pn;
  stg_t              s0, last, fin;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv && !flush;
  always_comb begin
    ra     = in_op == 3'd4 ? XLEN'(signed'(in_opa[31:0])) : in_opa;
    rb     = in_op == 3'd4 ? XLEN'(signed'(in_opb[31:0])) : in_opb;
    na     = (in_op inside {3'd0, 3'd1, 3'd2, 3'd4}) && ra[XLEN-1];
    nb     = (in_op inside {3'd0, 3'd1, 3'd4}) && rb[XLEN-1];
    ma     = na ? -ra : ra;
    mb     = nb ? -rb : rb;
    s0.vld = in_valid;
    s0.ill = in_op > 3'd4 || (in_op == 3'd4 && (xlen32 || XLEN == 32));
    s0.neg = na ^ nb;
    s0.sel = in_op == 3'd0 ? 2'd0 : in_op == 3'd4 ? 2'd2 : 2'd1;
    s0.tag = in_tag;
    s0.p   = {ma, mb};
  end
  always_comb begin
    fin = mul_at(last, LATENCY);
    pn  = fin.neg ? -fin.p : fin.p;
    res = fin.ill ? '0 :
          fin.sel == 2'd1 ? pn[2*XLEN-1:XLEN] :
          fin.sel == 2'd2 ? XLEN'(signed'(pn[31:0])) : pn[XLEN-1:0];
  end
  if (LATENCY > 1) begin : g_pipe
    stg_t r [1:LATENCY-1];
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) for (int k = 1; k < LATENCY; k++) r[k] <= '0;
      else if (flush) for (int k = 1; k < LATENCY; k++) r[k].vld <= 1'b0;
      else if (adv) begin
        r[1] <= s0;
        for (int k = 2; k < LATENCY; k++) r[k] <= mul_at(r[k-1], k);
      end
    always_comb begin
      mid_busy = 1'b0;
      for (int k = 1; k < LATENCY; k++) mid_busy = mid_busy | r[k].vld;
    end
    assign last = r[LATENCY-1];
  end else begin : g_comb
    assign mid_busy = 1'b0;
    assign last     = s0;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      out_valid   <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
      out_r       <= '0;
    end else if (flush) out_valid <= 1'b0;
    else if (adv) begin
      out_valid   <= fin.vld;
      out_illegal <= fin.ill;
      out_tag     <= fin.tag;
      out_r       <= res;
    end
  assign busy = out_valid | mid_busy;
endmodule

// File: tb/tb_pu_riscv_mul_pipe.sv
// tb_pu_riscv_mul_pipe: scoreboard bench for the pipelined multiplier (XLEN=64, LATENCY=3)
module tb_pu_riscv_mul_pipe;
  typedef struct packed {
    logic [63:0] r;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;
  logic        clk = 1'b0, rstn = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, xlen32 = 1'b0;
  logic [2:0]  in_op = '0;
  logic [63:0] in_opa = '0, in_opb = '0;
  logic [4:0]  in_tag = '0;
  logic        in_ready, out_valid, out_illegal, busy;
  logic [63:0] out_r;
  logic [4:0]  out_tag;
  int          pass_cnt = 0, total_cnt = 0, cons = 0;
  logic        acc = 1'b0;
  exp_t        q[$];
  exp_t        cur_exp;

  pu_riscv_mul_pipe #(.XLEN(64), .LATENCY(3), .TAGW(5)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_opa(in_opa), .in_opb(in_opb), .in_tag(in_tag), .xlen32(xlen32),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag),
    .out_illegal(out_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [4:0] tag, input logic x32);
    logic [127:0] sa = {{64{a[63]}}, a};
    logic [127:0] sb = {{64{b[63]}}, b};
    logic [127:0] ua = {64'd0, a};
    logic [127:0] ub = {64'd0, b};
    logic [127:0] ss = sa * sb;
    logic [127:0] su = sa * ub;
    logic [127:0] uu = ua * ub;
    logic [63:0]  w  = a * b;
    exp_t e;
    e.tag = tag;
    e.ill = 1'b0;
    e.r   = '0;
    case (op)
      3'd0: e.r = uu[63:0];
      3'd1: e.r = ss[127:64];
      3'd2: e.r = su[127:64];
      3'd3: e.r = uu[127:64];
      3'd4: if (x32) e.ill = 1'b1; else e.r = {{32{w[31]}}, w[31:0]};
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic set_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, input logic x32);
    in_valid = 1'b1;
    in_op    = op;
    in_opa   = a;
    in_opb   = b;
    in_tag   = tag;
    xlen32   = x32;
    cur_exp  = model(op, a, b, tag, x32);
  endtask

  task automatic set_rand(input logic [4:0] tag);
    logic [2:0] op = 3'($urandom_range(0, 4));
    set_op(op, {$urandom, $urandom}, {$urandom, $urandom}, tag, $urandom_range(0, 7) == 0);
  endtask

  // one clock: score the output handshake and record the accept at the negedge, then move past the posedge
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      total_cnt++;
      if (q.size() == 0)
        $display("FAIL result_unexpected: got r=%h tag=%0d, want no result", out_r, out_tag);
      else begin
        e = q.pop_front();
        cons++;
        if (out_r !== e.r || out_tag !== e.tag || out_illegal !== e.ill)
          $display("FAIL result: got r=%h tag=%0d ill=%b, want r=%h tag=%0d ill=%b",
                   out_r, out_tag, out_illegal, e.r, e.tag, e.ill);
        else pass_cnt++;
      end
    end
    acc = in_valid && in_ready;
    if (flush) q.delete();
    else if (acc) q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_valid: got out_valid=%b busy=%b, want 0 0", out_valid, busy);
    else pass_cnt++;
    @(posedge clk);
    @(posedge clk);
    #1;
    total_cnt++;
    if (out_r !== 64'd0) $display("FAIL reset_r: got %h, want 0", out_r); else pass_cnt++;
    total_cnt++;
    if (out_tag !== 5'd0) $display("FAIL reset_tag: got %0d, want 0", out_tag); else pass_cnt++;
    total_cnt++;
    if (out_illegal !== 1'b0) $display("FAIL reset_illegal: got %b, want 0", out_illegal); else pass_cnt++;
    rstn = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_latency();
    int n;
    out_ready = 1'b1;
    set_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 1'b0);
    cur_exp.r = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    total_cnt++;
    if (n !== 3) $display("FAIL latency: got %0d cycles, want 3", n); else pass_cnt++;
    step();
  endtask

  task automatic test_ops();
    logic [2:0]  dop [6] = '{3'd2, 3'd1, 3'd0, 3'd4, 3'd4, 3'd6};
    logic [63:0] da  [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFD,
                             64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 64'd5};
    logic [63:0] db  [6] = '{64'd2, 64'h8000_0000_0000_0000, 64'd5, 64'd2, 64'd2, 64'd7};
    logic        dx  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] dr  [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF1,
                             64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0};
    logic        dil [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_op(dop[i], da[i], db[i], 5'(i), dx[i]);
      cur_exp.r   = dr[i];
      cur_exp.ill = dil[i];
      step();
    end
    for (int i = 0; i < 16; i++) begin
      set_rand(5'(i + 8));
      step();
    end
    in_valid = 1'b0;
    xlen32   = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      step();
      n++;
    end
    total_cnt++;
    if (q.size() != 0) $display("FAIL ops_drain: got %0d pending, want 0", q.size()); else pass_cnt++;
  endtask

  task automatic test_stall();
    int sent = 0, cyc = 0;
    logic stalled_prev = 1'b0;
    logic [63:0] held_r = '0;
    logic [4:0] held_tag = '0;
    cons = 0;
    while ((sent < 8 || q.size() != 0) && cyc < 100) begin
      out_ready = !(cyc >= 5 && cyc < 9);
      if (sent < 8) set_rand(5'(sent));
      else in_valid = 1'b0;
      #1;
      total_cnt++;
      if (in_ready !== !(out_valid && !out_ready))
        $display("FAIL stall_in_ready: got %b, want %b (cycle %0d)", in_ready, !(out_valid && !out_ready), cyc);
      else pass_cnt++;
      if (stalled_prev) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_r !== held_r || out_tag !== held_tag)
          $display("FAIL stall_hold: got v=%b r=%h tag=%0d, want v=1 r=%h tag=%0d",
                   out_valid, out_r, out_tag, held_r, held_tag);
        else pass_cnt++;
      end
      stalled_prev = out_valid && !out_ready;
      held_r       = out_r;
      held_tag     = out_tag;
      step();
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total_cnt++;
    if (cons !== 8) $display("FAIL stall_count: got %0d results, want 8", cons); else pass_cnt++;
  endtask

  task automatic test_flush();
    int n;
    logic seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_rand(5'(20 + i));
      step();
    end
    set_rand(5'd30);
    flush = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b, want 0", in_ready); else pass_cnt++;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL flush_clear: got out_valid=%b busy=%b, want 0 0", out_valid, busy);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | out_valid;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL flush_stale: got out_valid=1, want 0"); else pass_cnt++;
    set_op(3'd0, 64'd6, 64'd7, 5'd17, 1'b0);
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    total_cnt++;
    if (n !== 3) $display("FAIL flush_relatency: got %0d cycles, want 3", n); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_inflight();
    logic seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_rand(5'(24 + i));
      step();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL inflight_busy: got %b, want 1", busy); else pass_cnt++;
    rstn = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL inflight_reset: got out_valid=%b busy=%b, want 0 0", out_valid, busy);
    else pass_cnt++;
    q.delete();
    step();
    step();
    rstn = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL inflight_in_ready: got %b, want 1", in_ready); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | out_valid | busy;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL inflight_stale: got activity after reset, want none"); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ops();
    test_stall();
    test_flush();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, want completion");
    $fatal(1, "timeout");
  end
endmodule
